// File: rtl/envelope_phase_sequencer_pkg.sv
// Shared definitions for the envelope phase sequencer: phase encoding and level limits.
package env_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } envPhaseT;

  localparam int DEFAULT_WIDTH = 10;

  // Full-scale level for a width-bit level register.
  function automatic int maxLevel(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/envelope_phase_sequencer_step_counter.sv
// Envelope level register with start blanking and saturating up/down steps.
module env_step_counter
  import env_seq_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int START_BLANK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic             dirUp,
  input  logic [WIDTH-1:0] floorLevel,
  output logic [WIDTH-1:0] level
);

  localparam int               BLANK_W   = (START_BLANK < 1) ? 1 : $clog2(START_BLANK + 1);
  localparam logic [WIDTH-1:0] MAX_LEVEL = WIDTH'(maxLevel(WIDTH));

  logic [BLANK_W-1:0] blankCnt;
  logic               stepOk;

  assign stepOk = enable && (blankCnt == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level    <= '0;
      blankCnt <= '0;
    end else begin
      if (load) begin
        blankCnt <= BLANK_W'(START_BLANK);
      end else if (blankCnt != '0) begin
        blankCnt <= blankCnt - BLANK_W'(1);
      end

      // Up saturates at full scale; down stops at the floor of the current phase.
      if (stepOk) begin
        if (dirUp) begin
          if (level != MAX_LEVEL) level <= level + WIDTH'(1);
        end else if (level > floorLevel) begin
          level <= level - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/envelope_phase_sequencer.sv
// ADSR phase sequencer: drives one exponential incrementer per phase and steps the level on its pulses.
module envelope_phase_sequencer
  import env_seq_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int START_BLANK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gate,
  input  logic [WIDTH-1:0] attack_len,
  input  logic [WIDTH-1:0] decay_len,
  input  logic [WIDTH-1:0] sustain_level,
  input  logic [WIDTH-1:0] release_len,
  input  logic             inc_pulse,
  output logic             inc_start,
  output logic [WIDTH-1:0] inc_pulse_length,
  output logic [WIDTH-1:0] inc_max_out,
  output logic [WIDTH-1:0] level,
  output logic [2:0]       phase,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_LEVEL = WIDTH'(maxLevel(WIDTH));

  envPhaseT         phaseReg, phaseNext, reqPhase;
  logic             gateD, rise, fall;
  logic             reqValid, entry;
  logic [WIDTH-1:0] entryLen, entrySteps, sustainTarget;
  logic [WIDTH-1:0] attackSteps, decaySteps;
  logic             decayNeeded, stepPhase, stepEnable;

  assign rise        = gate & ~gateD;
  assign fall        = ~gate & gateD;
  assign attackSteps = MAX_LEVEL - level;
  assign decaySteps  = level - sustain_level;
  assign decayNeeded = level > sustain_level;
  assign stepPhase   = (phaseReg == ATTACK) || (phaseReg == DECAY) || (phaseReg == RELEASE);
  // A gate edge in the same cycle as a pulse takes priority and the pulse is lost.
  assign stepEnable  = inc_pulse & stepPhase & ~rise & ~fall;
  assign phase       = phaseReg;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    phaseNext  = phaseReg;
    reqValid   = 1'b0;
    reqPhase   = phaseReg;
    entry      = 1'b0;
    entryLen   = '0;
    entrySteps = '0;

    if (phaseReg != IDLE && fall) begin
      reqValid = 1'b1;
      reqPhase = RELEASE;
    end else if ((phaseReg == IDLE || phaseReg == RELEASE) && rise) begin
      reqValid = 1'b1;
      reqPhase = ATTACK;
    end else begin
      case (phaseReg)
        ATTACK:  if (level == MAX_LEVEL) begin
                   reqValid = 1'b1;
                   reqPhase = DECAY;
                 end
        DECAY:   if (level == sustainTarget) phaseNext = SUSTAIN;
        RELEASE: if (level == '0) phaseNext = IDLE;
        default: ;
      endcase
    end

    // Zero-step phases are skipped so the incrementer never sees a zero step count.
    if (reqValid) begin
      case (reqPhase)
        ATTACK: begin
          if (attackSteps != '0) begin
            phaseNext  = ATTACK;
            entry      = 1'b1;
            entryLen   = attack_len;
            entrySteps = attackSteps;
          end else if (decayNeeded) begin
            phaseNext  = DECAY;
            entry      = 1'b1;
            entryLen   = decay_len;
            entrySteps = decaySteps;
          end else begin
            phaseNext = SUSTAIN;
          end
        end
        DECAY: begin
          if (decayNeeded) begin
            phaseNext  = DECAY;
            entry      = 1'b1;
            entryLen   = decay_len;
            entrySteps = decaySteps;
          end else begin
            phaseNext = SUSTAIN;
          end
        end
        RELEASE: begin
          if (level != '0) begin
            phaseNext  = RELEASE;
            entry      = 1'b1;
            entryLen   = release_len;
            entrySteps = level;
          end else begin
            phaseNext = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gateD            <= 1'b0;
      phaseReg         <= IDLE;
      busy             <= 1'b0;
      inc_start        <= 1'b0;
      inc_pulse_length <= '0;
      inc_max_out      <= '0;
      sustainTarget    <= '0;
    end else begin
      gateD     <= gate;
      phaseReg  <= phaseNext;
      busy      <= (phaseNext != IDLE);
      inc_start <= entry;
      if (entry) begin
        inc_pulse_length <= entryLen;
        inc_max_out      <= entrySteps;
        sustainTarget    <= sustain_level;
      end
    end
  end

  env_step_counter #(
    .WIDTH      (WIDTH),
    .START_BLANK(START_BLANK)
  ) u_step_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (entry),
    .enable    (stepEnable),
    .dirUp     (phaseReg == ATTACK),
    .floorLevel(phaseReg == DECAY ? sustainTarget : '0),
    .level     (level)
  );

endmodule

// File: tb/tb_envelope_phase_sequencer.sv
// Scoreboard bench for envelope_phase_sequencer; the bench plays the incrementer by issuing inc_pulse.
module tb_envelope_phase_sequencer;
  import env_seq_pkg::*;

  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             reset, gate, inc_pulse;
  logic [WIDTH-1:0] attack_len, decay_len, sustain_level, release_len;
  logic             inc_start, busy;
  logic [WIDTH-1:0] inc_pulse_length, inc_max_out, level;
  logic [2:0]       phase;

  int checks   = 0;
  int failures = 0;
  int evCount  = 0;

  typedef struct packed {
    logic [2:0]       ph;
    logic             start;
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] len;
    logic [WIDTH-1:0] maxOut;
    logic             bsy;
  } obsT;

  obsT        expQ[$];
  logic       monEn     = 1'b0;
  logic [2:0] lastPhase = 3'd0;

  always #5 clk = ~clk;

  envelope_phase_sequencer #(.WIDTH(WIDTH), .START_BLANK(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .gate            (gate),
    .attack_len      (attack_len),
    .decay_len       (decay_len),
    .sustain_level   (sustain_level),
    .release_len     (release_len),
    .inc_pulse       (inc_pulse),
    .inc_start       (inc_start),
    .inc_pulse_length(inc_pulse_length),
    .inc_max_out     (inc_max_out),
    .level           (level),
    .phase           (phase),
    .busy            (busy)
  );

  function automatic string fmt(input obsT o);
    return $sformatf("phase=%0d start=%0b level=%0d len=%0d max=%0d busy=%0b",
                     o.ph, o.start, o.lvl, o.len, o.maxOut, o.bsy);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expectEvent(input envPhaseT ph, input logic st, input int lvl, input int len,
                             input int mx, input logic b);
    obsT e;
    e.ph     = ph;
    e.start  = st;
    e.lvl    = WIDTH'(lvl);
    e.len    = WIDTH'(len);
    e.maxOut = WIDTH'(mx);
    e.bsy    = b;
    expQ.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issuePulses(input int n);
    repeat (n) begin
      @(negedge clk);
      inc_pulse = 1'b1;
      @(negedge clk);
      inc_pulse = 1'b0;
    end
  endtask

  // Monitor: an event is any inc_start or any change of phase.
  always @(negedge clk) begin
    obsT got;
    obsT want;
    got = {phase, inc_start, level, inc_pulse_length, inc_max_out, busy};
    if (monEn && (inc_start || phase != lastPhase)) begin
      evCount++;
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL event%0d unexpected: got %s expected none", evCount, fmt(got));
      end else begin
        want = expQ.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL event%0d: got %s expected %s", evCount, fmt(got), fmt(want));
        end
      end
    end
    lastPhase = phase;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    gate          = 1'b0;
    inc_pulse     = 1'b0;
    attack_len    = 10'd100;
    decay_len     = 10'd37;
    sustain_level = 10'd512;
    release_len   = 10'd60;
    waitCycles(2);
    check("reset_level", level, 0);
    check("reset_phase", phase, IDLE);
    check("reset_start", inc_start, 0);
    check("reset_busy", busy, 0);
    check("reset_len", inc_pulse_length, 0);
    check("reset_max", inc_max_out, 0);
    reset = 1'b0;
    waitCycles(2);
    monEn = 1'b1;

    // Full ADSR cycle from zero.
    expectEvent(ATTACK, 1, 0, 100, 1023, 1);
    gate = 1'b1;
    @(negedge clk);
    inc_pulse = 1'b1;
    waitCycles(4);
    inc_pulse = 1'b0;
    check("attack_blanked", level, 0);
    expectEvent(DECAY, 1, 1023, 37, 511, 1);
    issuePulses(1023);
    check("attack_top", level, 1023);
    waitCycles(1);
    decay_len = 10'd99;
    waitCycles(5);
    expectEvent(SUSTAIN, 0, 512, 37, 511, 1);
    issuePulses(511);
    waitCycles(2);
    check("decay_phase", phase, SUSTAIN);
    check("decay_level", level, 512);
    sustain_level = 10'd300;
    issuePulses(5);
    check("sustain_hold", level, 512);
    expectEvent(RELEASE, 1, 512, 60, 512, 1);
    gate = 1'b0;
    waitCycles(6);
    expectEvent(IDLE, 0, 0, 60, 512, 0);
    issuePulses(512);
    waitCycles(2);
    check("release_level", level, 0);
    check("release_busy", busy, 0);

    // Early release with a coincident pulse, then retrigger from the release level.
    attack_len    = 10'd50;
    sustain_level = 10'd512;
    release_len   = 10'd80;
    expectEvent(ATTACK, 1, 0, 50, 1023, 1);
    gate = 1'b1;
    waitCycles(6);
    issuePulses(200);
    waitCycles(1);
    check("attack_200", level, 200);
    expectEvent(RELEASE, 1, 200, 80, 200, 1);
    gate      = 1'b0;
    inc_pulse = 1'b1;
    @(negedge clk);
    inc_pulse = 1'b0;
    check("fall_drops_pulse", level, 200);
    waitCycles(6);
    issuePulses(50);
    waitCycles(1);
    check("release_150", level, 150);
    attack_len = 10'd70;
    expectEvent(ATTACK, 1, 150, 70, 873, 1);
    gate = 1'b1;
    waitCycles(6);
    issuePulses(150);
    waitCycles(1);
    check("attack_300", level, 300);

    // Asynchronous reset in the middle of ATTACK.
    expectEvent(IDLE, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_level", level, 0);
    check("midreset_phase", phase, IDLE);
    check("midreset_start", inc_start, 0);
    check("midreset_busy", busy, 0);
    gate = 1'b0;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(2);

    // Zero-step skips: DECAY with sustain at full scale, RELEASE from level 0.
    attack_len    = 10'd20;
    sustain_level = 10'd1023;
    release_len   = 10'd90;
    expectEvent(ATTACK, 1, 0, 20, 1023, 1);
    gate = 1'b1;
    waitCycles(6);
    expectEvent(SUSTAIN, 0, 1023, 20, 1023, 1);
    issuePulses(1023);
    check("skip_decay_pre", phase, ATTACK);
    waitCycles(1);
    check("skip_decay_phase", phase, SUSTAIN);
    check("skip_decay_start", inc_start, 0);
    expectEvent(RELEASE, 1, 1023, 90, 1023, 1);
    gate = 1'b0;
    waitCycles(6);
    expectEvent(IDLE, 0, 0, 90, 1023, 0);
    issuePulses(1023);
    waitCycles(3);
    expectEvent(ATTACK, 1, 0, 20, 1023, 1);
    expectEvent(IDLE, 0, 0, 20, 1023, 0);
    gate = 1'b1;
    @(negedge clk);
    gate = 1'b0;
    @(negedge clk);
    check("skip_release_phase", phase, IDLE);
    check("skip_release_start", inc_start, 0);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending events expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
